// File: rtl/mc_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller_pkg
// Description : Shared opcodes, ALU encodings, FSM states and fault causes
//               for the multi-cycle RV64 control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_controller_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_IMEM_TO = 2'b10,
    CAUSE_DMEM_TO = 2'b11
  } cause_t;

  // ld and sd share one class: both compute base + offset on the ALU
  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_RTYPE  = 2'd1,
    CLS_MEM    = 2'd2,
    CLS_BRANCH = 2'd3
  } op_class_t;

  function automatic op_class_t classify(input logic [6:0] opcode);
    op_class_t cls;
    case (opcode)
      OP_RTYPE:           cls = CLS_RTYPE;
      OP_LOAD, OP_STORE:  cls = CLS_MEM;
      OP_BRANCH:          cls = CLS_BRANCH;
      default:            cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller_if
// Description : Instruction/data handshake and datapath control bundle
//               between the control FSM and the datapath/memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_controller_if #(
  parameter int CNT_W = 64
);
  logic [31:0]      instruction;
  logic             zero;
  logic             imem_ack;
  logic             dmem_ack;
  logic             imem_req;
  logic             dmem_req;
  logic             dmem_we;
  logic             memtoreg;
  logic             alusrc;
  logic             regwrite;
  logic             pcsrc;
  logic             pc_en;
  logic [3:0]       alu_operation;
  logic             fault;
  logic [1:0]       fault_cause;
  logic [CNT_W-1:0] instret;

  modport master (
    input  instruction, zero, imem_ack, dmem_ack,
    output imem_req, dmem_req, dmem_we, memtoreg, alusrc, regwrite,
           pcsrc, pc_en, alu_operation, fault, fault_cause, instret
  );

  modport slave (
    output instruction, zero, imem_ack, dmem_ack,
    input  imem_req, dmem_req, dmem_we, memtoreg, alusrc, regwrite,
           pcsrc, pc_en, alu_operation, fault, fault_cause, instret
  );
endinterface
`default_nettype wire

// File: rtl/mc_controller_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Maps instruction class, funct3 and funct7[5] to an ALU
//               operation code and flags unsupported encodings.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
  import mc_controller_pkg::*;
(
  input  op_class_t  i_op_class,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_b5,
  output logic [3:0] o_alu_operation,
  output logic       o_illegal
);

  always_comb begin
    o_alu_operation = ALU_ADD;
    o_illegal       = 1'b0;
    case (i_op_class)
      CLS_RTYPE: begin
        case (i_funct3)
          3'b000:  o_alu_operation = i_funct7_b5 ? ALU_SUB : ALU_ADD;
          3'b110:  o_alu_operation = ALU_OR;
          3'b111:  o_alu_operation = ALU_AND;
          default: o_illegal       = 1'b1;
        endcase
      end
      CLS_MEM: o_alu_operation = ALU_ADD;
      CLS_BRANCH: begin
        // beq compares by subtraction; the datapath reports equality on zero
        o_alu_operation = ALU_SUB;
        o_illegal       = (i_funct3 != 3'b000);
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller
// Description : Multi-cycle control FSM for the RV64 integer datapath with
//               handshaked memories, fault trapping and instret counting.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 64
) (
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.master bus
);

  // The wait counter compares against the last tolerated count so an ack
  // landing in the cycle the budget runs out still wins.
  localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [6:0]       r_opcode;
  logic [2:0]       r_funct3;
  logic             r_funct7_b5;
  logic [15:0]      r_wait_cnt;
  logic [CNT_W-1:0] r_instret;
  cause_t           r_cause;
  cause_t           w_cause_next;

  op_class_t  w_class;
  logic       w_is_store;
  logic       w_is_load;
  logic       w_wait_expired;
  logic [3:0] w_dec_alu_op;
  logic       w_dec_illegal;

  logic       w_imem_req;
  logic       w_dmem_req;
  logic       w_dmem_we;
  logic       w_memtoreg;
  logic       w_alusrc;
  logic       w_regwrite;
  logic       w_pcsrc;
  logic       w_pc_en;
  logic [3:0] w_alu_op;
  logic       w_fault;

  assign w_class        = classify(r_opcode);
  assign w_is_store     = (r_opcode == OP_STORE);
  assign w_is_load      = (r_opcode == OP_LOAD);
  assign w_wait_expired = (r_wait_cnt == c_timeout_last);

  alu_decoder u_alu_decoder (
    .i_op_class      (w_class),
    .i_funct3        (r_funct3),
    .i_funct7_b5     (r_funct7_b5),
    .o_alu_operation (w_dec_alu_op),
    .o_illegal       (w_dec_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= FETCH;
      r_opcode    <= 7'd0;
      r_funct3    <= 3'd0;
      r_funct7_b5 <= 1'b0;
      r_wait_cnt  <= 16'd0;
      r_instret   <= '0;
      r_cause     <= CAUSE_NONE;
    end else begin
      r_state <= w_state_next;
      r_cause <= w_cause_next;
      if (r_state == FETCH && bus.imem_ack) begin
        r_opcode    <= bus.instruction[6:0];
        r_funct3    <= bus.instruction[14:12];
        r_funct7_b5 <= bus.instruction[30];
      end
      // Any state change restarts the count, covering entry to FETCH and MEM
      if (w_state_next != r_state) begin
        r_wait_cnt <= 16'd0;
      end else if (r_state == FETCH || r_state == MEM) begin
        r_wait_cnt <= r_wait_cnt + 16'd1;
      end
      if (w_pc_en) begin
        r_instret <= r_instret + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cause_next = r_cause;
    w_imem_req   = 1'b0;
    w_dmem_req   = 1'b0;
    w_dmem_we    = 1'b0;
    w_memtoreg   = 1'b0;
    w_alusrc     = 1'b0;
    w_regwrite   = 1'b0;
    w_pcsrc      = 1'b0;
    w_pc_en      = 1'b0;
    w_alu_op     = ALU_AND;
    w_fault      = 1'b0;

    case (r_state)
      FETCH: begin
        w_imem_req = 1'b1;
        if (bus.imem_ack) begin
          w_state_next = DECODE;
        end else if (w_wait_expired) begin
          w_state_next = TRAP;
          w_cause_next = CAUSE_IMEM_TO;
        end
      end
      DECODE: begin
        if (w_class == CLS_NONE) begin
          w_state_next = TRAP;
          w_cause_next = CAUSE_ILLEGAL;
        end else begin
          w_state_next = EXEC;
        end
      end
      EXEC: begin
        w_alusrc = (w_class == CLS_MEM);
        w_alu_op = w_dec_alu_op;
        if (w_dec_illegal) begin
          w_state_next = TRAP;
          w_cause_next = CAUSE_ILLEGAL;
        end else begin
          case (w_class)
            CLS_RTYPE: w_state_next = WB;
            CLS_MEM:   w_state_next = MEM;
            default: begin
              w_pc_en      = 1'b1;
              w_pcsrc      = bus.zero;
              w_state_next = FETCH;
            end
          endcase
        end
      end
      MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = w_is_store;
        w_alusrc   = 1'b1;
        w_alu_op   = ALU_ADD;
        if (bus.dmem_ack) begin
          if (w_is_store) begin
            w_pc_en      = 1'b1;
            w_state_next = FETCH;
          end else begin
            w_state_next = WB;
          end
        end else if (w_wait_expired) begin
          w_state_next = TRAP;
          w_cause_next = CAUSE_DMEM_TO;
        end
      end
      WB: begin
        w_regwrite   = 1'b1;
        w_pc_en      = 1'b1;
        w_memtoreg   = w_is_load;
        w_alusrc     = (w_class == CLS_MEM);
        w_alu_op     = w_dec_alu_op;
        w_state_next = FETCH;
      end
      TRAP: begin
        w_fault = 1'b1;
      end
      default: begin
        w_state_next = FETCH;
      end
    endcase

    // Reset forces FETCH immediately; keep the bus quiet until it releases
    if (reset) begin
      w_imem_req = 1'b0;
      w_dmem_req = 1'b0;
      w_dmem_we  = 1'b0;
      w_regwrite = 1'b0;
      w_pc_en    = 1'b0;
      w_pcsrc    = 1'b0;
    end
  end

  assign bus.imem_req      = w_imem_req;
  assign bus.dmem_req      = w_dmem_req;
  assign bus.dmem_we       = w_dmem_we;
  assign bus.memtoreg      = w_memtoreg;
  assign bus.alusrc        = w_alusrc;
  assign bus.regwrite      = w_regwrite;
  assign bus.pcsrc         = w_pcsrc;
  assign bus.pc_en         = w_pc_en;
  assign bus.alu_operation = w_alu_op;
  assign bus.fault         = w_fault;
  assign bus.fault_cause   = r_cause;
  assign bus.instret       = r_instret;

endmodule
`default_nettype wire
